// File: rtl/boot_loader_if.sv
// UART boot loader control/memory-side signal bundle.
// The loader is the master: it drives the memory request and status lines.
interface boot_loader_if;
  logic       RX;
  logic       HALT;
  logic       CS;
  logic       WE;
  logic [6:0] ADDR;
  logic       LOAD_DONE;
  logic       FRAME_ERR;

  modport master (
    input  RX,
    output HALT, CS, WE, ADDR, LOAD_DONE, FRAME_ERR
  );

  modport slave (
    output RX,
    input  HALT, CS, WE, ADDR, LOAD_DONE, FRAME_ERR
  );
endinterface

// File: rtl/boot_loader.sv
// UART boot loader: receives a word count N then 4*N bytes (MSB first per word)
// and writes each assembled word to instruction memory while holding the CPU.
module boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_WORDS    = 128
) (
  input  logic         CLK,
  input  logic         RST,
  boot_loader_if.master bus,
  inout  wire  [31:0]  Mem_Bus
);

  localparam int         CW    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [8:0] MAX_W9 = 9'(MAX_WORDS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_COUNT, L_BYTES, L_WRITE, L_DONE, L_ERR} ld_state_t;

  rx_state_t       r_state;
  ld_state_t       l_state;
  logic            rx_p0, rx_p1, rx_p2;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_shift;
  logic            byte_vld;
  logic            stop_err;
  logic [7:0]      word_cnt;
  logic [7:0]      word_idx;
  logic [1:0]      byte_cnt;
  logic [31:0]     word_q;
  logic            halt, load_done, frame_err, cs, we;
  logic [6:0]      addr;

  // Stage p0/p1: metastability synchronizer; p2 holds the previous level for edge detect
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= bus.RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= R_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      stop_err <= 1'b0;
      case (r_state)
        R_IDLE: begin
          clk_cnt <= '0;
          if (rx_p2 && !rx_p1) r_state <= R_START;
        end
        R_START: begin
          // A start bit that is high again at mid-bit was a glitch
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            r_state <= rx_p1 ? R_IDLE : R_DATA;
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        R_DATA: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt  <= '0;
            rx_shift <= {rx_p1, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) r_state <= R_STOP;
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        R_STOP: begin
          if (clk_cnt == FULL_M1) begin
            clk_cnt <= '0;
            if (rx_p1) byte_vld <= 1'b1;
            else       stop_err <= 1'b1;
            r_state <= R_IDLE;
          end else clk_cnt <= clk_cnt + 1'b1;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      l_state   <= L_COUNT;
      word_cnt  <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      word_q    <= '0;
      halt      <= 1'b1;
      load_done <= 1'b0;
      frame_err <= 1'b0;
      cs        <= 1'b0;
      we        <= 1'b0;
      addr      <= '0;
    end else begin
      case (l_state)
        L_COUNT: begin
          if (stop_err || (byte_vld && (rx_shift == 8'd0 || {1'b0, rx_shift} > MAX_W9))) begin
            l_state   <= L_ERR;
            frame_err <= 1'b1;
          end else if (byte_vld) begin
            word_cnt <= rx_shift;
            byte_cnt <= '0;
            l_state  <= L_BYTES;
          end
        end
        L_BYTES: begin
          if (stop_err) begin
            l_state   <= L_ERR;
            frame_err <= 1'b1;
          end else if (byte_vld) begin
            word_q   <= {word_q[23:0], rx_shift};
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == 2'd3) begin
              l_state <= L_WRITE;
              cs      <= 1'b1;
              we      <= 1'b1;
              addr    <= word_idx[6:0];
            end
          end
        end
        L_WRITE: begin
          // Single-cycle strobe: memory latches on the negedge inside this cycle
          cs       <= 1'b0;
          we       <= 1'b0;
          addr     <= '0;
          word_idx <= word_idx + 8'd1;
          if (word_idx + 8'd1 == word_cnt) begin
            l_state   <= L_DONE;
            halt      <= 1'b0;
            load_done <= 1'b1;
          end else l_state <= L_BYTES;
        end
        L_DONE:  l_state <= L_DONE;
        L_ERR:   l_state <= L_ERR;
        default: l_state <= L_ERR;
      endcase
    end
  end

  assign bus.HALT      = halt;
  assign bus.LOAD_DONE = load_done;
  assign bus.FRAME_ERR = frame_err;
  assign bus.CS        = cs;
  assign bus.WE        = we;
  assign bus.ADDR      = addr;
  assign Mem_Bus       = cs ? word_q : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: dut_a at 16 clocks/bit for the functional
// scenarios, dut_b at 8 clocks/bit for the full 128-word capacity load.
module tb_boot_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  boot_loader_if bif_a ();
  boot_loader_if bif_b ();
  assign bif_a.RX = rx_a;
  assign bif_b.RX = rx_b;
  wire [31:0] mem_bus_a;
  wire [31:0] mem_bus_b;

  boot_loader #(.CLKS_PER_BIT(16), .MAX_WORDS(128)) dut_a (
    .CLK(clk), .RST(rst), .bus(bif_a.master), .Mem_Bus(mem_bus_a));
  boot_loader #(.CLKS_PER_BIT(8), .MAX_WORDS(128)) dut_b (
    .CLK(clk), .RST(rst), .bus(bif_b.master), .Mem_Bus(mem_bus_b));

  logic [31:0] ram_a [0:127];
  logic [31:0] ram_b [0:127];
  int   wr_a = 0, wr_b = 0, pulse_err_a = 0, pulse_err_b = 0, addr_err_b = 0;
  logic [6:0] last_addr_a = '0, last_addr_b = '0;
  logic cs_prev_a = 1'b0, cs_prev_b = 1'b0;

  always @(negedge clk) begin
    cs_prev_a <= bif_a.CS;
    if (bif_a.CS && cs_prev_a) pulse_err_a <= pulse_err_a + 1;
    if (bif_a.CS && bif_a.WE) begin
      ram_a[bif_a.ADDR] <= mem_bus_a;
      wr_a              <= wr_a + 1;
      last_addr_a       <= bif_a.ADDR;
    end
    cs_prev_b <= bif_b.CS;
    if (bif_b.CS && cs_prev_b) pulse_err_b <= pulse_err_b + 1;
    if (bif_b.CS && bif_b.WE) begin
      ram_b[bif_b.ADDR] <= mem_bus_b;
      wr_b              <= wr_b + 1;
      last_addr_b       <= bif_b.ADDR;
      if (32'(bif_b.ADDR) != wr_b) addr_err_b <= addr_err_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
    int p;
    p = sel ? 8 : 16;
    drive_bit(sel, 1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(sel, b[i], p);
    drive_bit(sel, stop, p);
    drive_bit(sel, 1'b1, 4);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bytes_037 [0:8];
    bytes_037 = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};

    // Reset values while RST is held
    repeat (3) @(negedge clk);
    check("rst_halt", 32'(bif_a.HALT), 32'd1);
    check("rst_load_done", 32'(bif_a.LOAD_DONE), 32'd0);
    check("rst_frame_err", 32'(bif_a.FRAME_ERR), 32'd0);
    check("rst_cs", 32'(bif_a.CS), 32'd0);
    check("rst_we", 32'(bif_a.WE), 32'd0);
    check("rst_addr", 32'(bif_a.ADDR), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Two-word program
    for (int i = 0; i < 9; i++) send_byte(1'b0, bytes_037[i], 1'b1);
    repeat (5) @(negedge clk);
    check("prog_ram0", ram_a[0], 32'h2001_0005);
    check("prog_ram1", ram_a[1], 32'hAC01_0000);
    check("prog_writes", 32'(wr_a), 32'd2);
    check("prog_last_addr", 32'(last_addr_a), 32'd1);
    check("prog_halt", 32'(bif_a.HALT), 32'd0);
    check("prog_load_done", 32'(bif_a.LOAD_DONE), 32'd1);
    check("prog_frame_err", 32'(bif_a.FRAME_ERR), 32'd0);
    check("prog_cs_idle", 32'(bif_a.CS), 32'd0);
    send_byte(1'b0, 8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    check("done_extra_byte_writes", 32'(wr_a), 32'd2);
    check("done_still_done", 32'(bif_a.LOAD_DONE), 32'd1);

    // Short low glitch on idle line, then a clean one-word load
    do_reset();
    drive_bit(1'b0, 1'b0, 4);
    drive_bit(1'b0, 1'b1, 40);
    check("glitch_frame_err", 32'(bif_a.FRAME_ERR), 32'd0);
    check("glitch_halt", 32'(bif_a.HALT), 32'd1);
    check("glitch_writes", 32'(wr_a), 32'd2);
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b0, 8'h12, 1'b1);
    send_byte(1'b0, 8'h34, 1'b1);
    send_byte(1'b0, 8'h56, 1'b1);
    send_byte(1'b0, 8'h78, 1'b1);
    repeat (5) @(negedge clk);
    check("glitch_load_ram0", ram_a[0], 32'h1234_5678);
    check("glitch_load_addr", 32'(last_addr_a), 32'd0);
    check("glitch_load_writes", 32'(wr_a), 32'd3);
    check("glitch_load_done", 32'(bif_a.LOAD_DONE), 32'd1);

    // N = 0 is rejected
    do_reset();
    send_byte(1'b0, 8'h00, 1'b1);
    repeat (5) @(negedge clk);
    check("n0_frame_err", 32'(bif_a.FRAME_ERR), 32'd1);
    check("n0_halt", 32'(bif_a.HALT), 32'd1);
    check("n0_writes", 32'(wr_a), 32'd3);

    // N above capacity is rejected
    do_reset();
    check("n129_err_cleared", 32'(bif_a.FRAME_ERR), 32'd0);
    send_byte(1'b0, 8'h81, 1'b1);
    repeat (5) @(negedge clk);
    check("n129_frame_err", 32'(bif_a.FRAME_ERR), 32'd1);
    check("n129_load_done", 32'(bif_a.LOAD_DONE), 32'd0);

    // Bad stop bit, then a full word that must not be written
    do_reset();
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b0, 8'h55, 1'b0);
    repeat (5) @(negedge clk);
    check("stop_frame_err", 32'(bif_a.FRAME_ERR), 32'd1);
    check("stop_halt", 32'(bif_a.HALT), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(1'b0, 8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    check("stop_no_write", 32'(wr_a), 32'd3);
    check("stop_err_held", 32'(bif_a.FRAME_ERR), 32'd1);

    // Reset halfway through word 0, then reload
    do_reset();
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b0, 8'h11, 1'b1);
    send_byte(1'b0, 8'h22, 1'b1);
    do_reset();
    check("abort_halt", 32'(bif_a.HALT), 32'd1);
    check("abort_writes", 32'(wr_a), 32'd3);
    check("abort_frame_err", 32'(bif_a.FRAME_ERR), 32'd0);
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b0, 8'hDE, 1'b1);
    send_byte(1'b0, 8'hAD, 1'b1);
    send_byte(1'b0, 8'hBE, 1'b1);
    send_byte(1'b0, 8'hEF, 1'b1);
    repeat (5) @(negedge clk);
    check("reload_ram0", ram_a[0], 32'hDEAD_BEEF);
    check("reload_addr", 32'(last_addr_a), 32'd0);
    check("reload_writes", 32'(wr_a), 32'd4);
    check("reload_halt", 32'(bif_a.HALT), 32'd0);
    check("a_cs_single_cycle", 32'(pulse_err_a), 32'd0);

    // Full-capacity load on the fast instance
    do_reset();
    send_byte(1'b1, 8'h80, 1'b1);
    for (int i = 0; i < 512; i++) send_byte(1'b1, 8'(i), 1'b1);
    repeat (5) @(negedge clk);
    check("max_writes", 32'(wr_b), 32'd128);
    check("max_last_addr", 32'(last_addr_b), 32'd127);
    check("max_addr_sequence", 32'(addr_err_b), 32'd0);
    check("max_ram0", ram_b[0], 32'h0001_0203);
    check("max_ram127", ram_b[127], 32'hFCFD_FEFF);
    check("max_load_done", 32'(bif_b.LOAD_DONE), 32'd1);
    check("max_halt", 32'(bif_b.HALT), 32'd0);
    send_byte(1'b1, 8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    check("max_extra_no_write", 32'(wr_b), 32'd128);
    check("b_cs_single_cycle", 32'(pulse_err_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, CLK cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter: MAX_WORDS, default 128, capacity of instruction memory in words.
REQ-003 Port: CLK  input  1  system clock; all state changes on posedge CLK.
REQ-004 Port: RST  input  1  reset, synchronous, active-high.
REQ-005 Port: RX  input  1  UART serial data, idle high, asynchronous to CLK.
REQ-006 Port: HALT  output  1  hold request to the CPU; high while a program is being loaded.
REQ-007 Port: CS  output  1  memory chip select; ORed with the CPU's CS at top level.
REQ-008 Port: WE  output  1  memory write enable; ORed with the CPU's WE at top level.
REQ-009 Port: ADDR  output  7  memory word address; muxed with the CPU's ADDR on HALT at top level.
REQ-010 Port: Mem_Bus  inout  32  memory data bus; driven only during a write cycle, else high-Z.
REQ-011 Port: LOAD_DONE  output  1  high once the program is completely written.
REQ-012 Port: FRAME_ERR  output  1  sticky error flag.

Function
REQ-013 RX SHALL pass through a 2-flop synchronizer before any use.
REQ-014 Receiver FSM SHALL have states R_IDLE, R_START, R_DATA and R_STOP.
REQ-015 R_IDLE -> R_START on a synchronized falling edge of RX.
REQ-016 In R_START, RX SHALL be sampled CLKS_PER_BIT/2 cycles after the edge: low -> R_DATA; high -> R_IDLE (glitch, no error).
REQ-017 In R_DATA, 8 bits SHALL be sampled LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-018 In R_STOP, RX SHALL be sampled after CLKS_PER_BIT cycles.
REQ-019 Stop bit high SHALL produce a 1-cycle byte_valid pulse with the byte, then R_IDLE.
REQ-020 Stop bit low SHALL set FRAME_ERR, discard the byte and send the loader to L_ERR.
REQ-021 Loader FSM SHALL have states L_COUNT, L_BYTES, L_WRITE, L_DONE and L_ERR.
REQ-022 L_COUNT: the first received byte SHALL be the word count N.
REQ-023 L_COUNT with N in 1..MAX_WORDS -> L_BYTES; N = 0 or N > MAX_WORDS -> L_ERR with FRAME_ERR set.
REQ-024 L_BYTES SHALL shift bytes into a 32-bit word MSB first (the first byte lands in bits 31:24) and enter L_WRITE after the 4th byte.
REQ-025 L_WRITE SHALL last exactly one CLK cycle with CS=1, WE=1, ADDR=word index and Mem_Bus=assembled word, so the memory captures it on the intervening negedge.
REQ-026 After L_WRITE the word index SHALL increment.
REQ-027 After L_WRITE: index = N -> L_DONE; otherwise -> L_BYTES.
REQ-028 The first word SHALL be written to address 0; addresses SHALL never exceed N-1, so there is no wrap-around.
REQ-029 Bytes arriving during L_WRITE are impossible by timing (at least 10*CLKS_PER_BIT cycles apart); no buffering is required.
REQ-030 L_DONE: HALT=0 and LOAD_DONE=1, held until RST; further RX bytes SHALL be ignored; CS=WE=0; Mem_Bus=Z.
REQ-031 L_ERR: HALT=1, FRAME_ERR=1, no memory writes, held until RST.
REQ-032 Outside L_WRITE, CS, WE and ADDR SHALL be 0 and Mem_Bus SHALL be Z.

Reset
REQ-033 While RST=1, the block SHALL enter R_IDLE and L_COUNT and clear the word index, the shift register and the bit counters.
REQ-034 Reset output values: HALT=1, LOAD_DONE=0, FRAME_ERR=0, CS=0, WE=0, ADDR=0, Mem_Bus=Z.
REQ-035 RST asserted mid-load SHALL abort immediately; the load restarts at L_COUNT; words already written SHALL stay in memory.
REQ-036 RST asserted in the same cycle as a scheduled write SHALL win, and no write SHALL occur.

Verification (CLKS_PER_BIT=16)
REQ-037 Send bytes 02, 20,01,00,05, AC,01,00,00 -> RAM[0]=32'h20010005 and RAM[1]=32'hAC010000, each with a single 1-cycle CS/WE pulse; then HALT=0 and LOAD_DONE=1.
REQ-038 Send N=0x00 -> FRAME_ERR=1, HALT stays 1, no CS pulse observed.
REQ-039 Send N=0x01 then a byte with stop bit forced low -> FRAME_ERR=1, no memory write, HALT stays 1.
REQ-040 Apply a 4-cycle low glitch on RX while idle -> no byte_valid pulse, no error, state unchanged.
REQ-041 Send N=0x80 followed by 512 bytes -> last write goes to ADDR=7'd127, then L_DONE; an extra byte afterwards -> no write.
REQ-042 Pulse RST after 2 of 4 bytes of word 0 -> HALT=1, no write; reloading N=01 plus 4 bytes writes ADDR 0 correctly.
